// File: rtl/beep_sequencer.sv
// Priority beep arbiter: plays N on/off beeps of a divider tone for the lowest-index requester; BEEP_PREEMPT_EN enables preemption.
// Latency: Ack/Busy one edge after Req in IDLE; Buzzer lags the tone input by one cycle.
// Backpressure: requesters hold Req until Ack; requests arriving while busy wait for the next IDLE cycle.
module beep_sequencer #(
    parameter int CLK_HZ = 40_000_000,
    parameter int ON_MS  = 100,
    parameter int OFF_MS = 100
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Tone500,
    input  logic        Tone1k,
    input  logic        Tone2k,
    input  logic [2:0]  Req,
    input  logic [5:0]  ReqTone,
    input  logic [11:0] ReqCount,
    output logic [2:0]  Ack,
    output logic [2:0]  Done,
    output logic [2:0]  Abort,
    output logic        Busy,
    output logic [1:0]  Owner,
    output logic        Buzzer
);

    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int PW     = $clog2(MS_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [9:0]    phase_q;
    logic [3:0]    cnt_q;
    logic [1:0]    tone_q;
    logic [1:0]    owner_q;

    logic          ms_tick, phase_end, preempt, grant, beep_end;
    logic [1:0]    gnt_idx, req_tone, tone_code;
    logic [3:0]    req_cnt;
    logic [2:0]    gnt_oh, own_oh;
    logic [2:0]    ack_d, done_d, abort_d;
    logic          buz_d;

    assign ms_tick   = (presc_q == PW'(MS_CYC - 1));
    assign phase_end = ms_tick && (phase_q == 10'd1);
    assign gnt_oh    = 3'b001 << gnt_idx;
    assign own_oh    = 3'b001 << owner_q;
    assign Busy      = (state_q != S_IDLE);
    assign Owner     = owner_q;

    always_comb begin
        gnt_idx  = 2'd2;
        req_tone = ReqTone[5:4];
        req_cnt  = ReqCount[11:8];
        if (Req[0]) begin
            gnt_idx  = 2'd0;
            req_tone = ReqTone[1:0];
            req_cnt  = ReqCount[3:0];
        end else if (Req[1]) begin
            gnt_idx  = 2'd1;
            req_tone = ReqTone[3:2];
            req_cnt  = ReqCount[7:4];
        end
    end

`ifdef BEEP_PREEMPT_EN
    // Only a strictly lower index can steal the buzzer.
    assign preempt = (state_q != S_IDLE) &&
                     (((owner_q == 2'd1) && Req[0]) || ((owner_q == 2'd2) && (|Req[1:0])));
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ack_d    = 3'b000;
        done_d   = 3'b000;
        abort_d  = 3'b000;
        grant    = 1'b0;
        beep_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|Req) begin
                    ack_d = gnt_oh;
                    if (req_cnt == 4'd0) begin
                        done_d = gnt_oh;
                    end else begin
                        grant   = 1'b1;
                        state_d = S_ON;
                    end
                end
            end
            S_ON: begin
                if (preempt) begin
                    abort_d = own_oh;
                    state_d = S_IDLE;
                end else if (phase_end) begin
                    state_d = S_OFF;
                end
            end
            S_OFF: begin
                if (preempt) begin
                    abort_d = own_oh;
                    state_d = S_IDLE;
                end else if (phase_end) begin
                    beep_end = 1'b1;
                    if (cnt_q == 4'd1) begin
                        done_d  = own_oh;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ON;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Buzzer follows the next state so it drops on the same edge as a preempt or beep end.
    always_comb begin
        tone_code = grant ? req_tone : tone_q;
        buz_d     = 1'b0;
        if (state_d == S_ON) begin
            case (tone_code)
                2'b00:   buz_d = Tone500;
                2'b01:   buz_d = Tone1k;
                2'b10:   buz_d = Tone2k;
                default: buz_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            tone_q  <= '0;
            owner_q <= 2'd3;
            Ack     <= '0;
            Done    <= '0;
            Abort   <= '0;
            Buzzer  <= 1'b0;
        end else begin
            state_q <= state_d;
            Ack     <= ack_d;
            Done    <= done_d;
            Abort   <= abort_d;
            Buzzer  <= buz_d;

            if (grant || ms_tick) presc_q <= '0;
            else                  presc_q <= presc_q + 1'b1;

            if (state_d != state_q) begin
                case (state_d)
                    S_ON:    phase_q <= 10'(ON_MS);
                    S_OFF:   phase_q <= 10'(OFF_MS);
                    default: phase_q <= '0;
                endcase
            end else if (ms_tick && (state_q != S_IDLE)) begin
                phase_q <= phase_q - 10'd1;
            end

            if (grant) begin
                cnt_q   <= req_cnt;
                tone_q  <= req_tone;
                owner_q <= gnt_idx;
            end else begin
                if (beep_end) cnt_q <= cnt_q - 4'd1;
                if (state_d == S_IDLE) owner_q <= 2'd3;
            end
        end
    end

endmodule

// File: tb/tb_beep_sequencer.sv
// Scoreboard bench for beep_sequencer at 10 cycles/ms, ON=2 ms, OFF=3 ms.
module tb_beep_sequencer;

    localparam int MS  = 10;
    localparam int ONC = 2 * MS;
    localparam int PER = 5 * MS;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Tone500 = 1'b0, Tone1k = 1'b0, Tone2k = 1'b0;
    logic [2:0]  Req = '0;
    logic [5:0]  ReqTone = '0;
    logic [11:0] ReqCount = '0;
    logic [2:0]  Ack, Done, Abort;
    logic        Busy;
    logic [1:0]  Owner;
    logic        Buzzer;

    int vec = 0;
    int miss = 0;

    int exp_q[$];
    int obs_q[$];
    logic       buz_tr [0:255];
    logic       t1k_tr [0:255];
    logic       t2k_tr [0:255];
    logic       busy_tr[0:255];
    logic [1:0] own_tr [0:255];
    int tc = 0;

    beep_sequencer #(.CLK_HZ(10_000), .ON_MS(2), .OFF_MS(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Tone500(Tone500), .Tone1k(Tone1k), .Tone2k(Tone2k),
        .Req(Req), .ReqTone(ReqTone), .ReqCount(ReqCount),
        .Ack(Ack), .Done(Done), .Abort(Abort),
        .Busy(Busy), .Owner(Owner), .Buzzer(Buzzer)
    );

    always #5 Clk = ~Clk;

    // Distinct bench tone patterns, changed only on the falling edge.
    always @(negedge Clk) begin
        tc = tc + 1;
        Tone2k  = tc[0];
        Tone1k  = (tc % 3) == 0;
        Tone500 = tc[2];
    end

    function automatic int ev(input int kind, input int idx, input int step);
        return kind * 10000 + idx * 1000 + step;
    endfunction

    // Steps n edges, logging events and traces; models requesters dropping Req on Ack.
    task automatic run(input int n, input int raise_step, input logic [2:0] raise_mask);
        obs_q.delete();
        for (int s = 1; s <= n; s++) begin
            @(posedge Clk);
            #1;
            buz_tr[s]  = Buzzer;
            t1k_tr[s]  = Tone1k;
            t2k_tr[s]  = Tone2k;
            busy_tr[s] = Busy;
            own_tr[s]  = Owner;
            for (int i = 0; i < 3; i++) if (Ack[i])   obs_q.push_back(ev(0, i, s));
            for (int i = 0; i < 3; i++) if (Done[i])  obs_q.push_back(ev(1, i, s));
            for (int i = 0; i < 3; i++) if (Abort[i]) obs_q.push_back(ev(2, i, s));
            Req = Req & ~Ack;
            if (s == raise_step) Req = Req | raise_mask;
        end
    endtask

    task automatic test_reset;
        logic [10:0] got;
        for (int c = 0; c < 12; c++) begin
            @(posedge Clk);
            #1;
            got = {Buzzer, Busy, Owner, Ack, Done, Abort};
            vec++;
            if (got !== 11'b00_11_000_000_000) begin
                miss++;
                $display("FAIL reset_hold: got %b want 00110000000", got);
            end
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk);
            #1;
            got = {Buzzer, Busy, Owner, Ack, Done, Abort};
            vec++;
            if (got !== 11'b00_11_000_000_000) begin
                miss++;
                $display("FAIL reset_release: got %b want 00110000000", got);
            end
        end
    endtask

    task automatic test_basic;
        logic e;
        int a, b;
        @(negedge Clk);
        Req = 3'b010; ReqTone = 6'b00_01_00; ReqCount = 12'h030;
        exp_q.push_back(ev(0, 1, 1));
        exp_q.push_back(ev(1, 1, 1 + 3 * PER));
        run(160, 0, 3'b000);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            a = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            b = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vec++;
            if (b !== a) begin miss++; $display("FAIL basic_event: got %0d want %0d", b, a); end
        end
        for (int s = 1; s <= 155; s++) begin
            e = (s <= 3 * PER && ((s - 1) % PER) < ONC) ? t1k_tr[s] : 1'b0;
            vec++;
            if (buz_tr[s] !== e) begin miss++; $display("FAIL basic_buzzer step %0d: got %b want %b", s, buz_tr[s], e); end
        end
        vec++;
        if (own_tr[5] !== 2'd1 || busy_tr[5] !== 1'b1) begin
            miss++; $display("FAIL basic_owner: got owner %0d busy %b want 1 1", own_tr[5], busy_tr[5]);
        end
        vec++;
        if (own_tr[151] !== 2'd3 || busy_tr[151] !== 1'b0) begin
            miss++; $display("FAIL basic_idle_after_done: got owner %0d busy %b want 3 0", own_tr[151], busy_tr[151]);
        end
    endtask

    task automatic test_priority;
        int a, b;
        @(negedge Clk);
        Req = 3'b101; ReqTone = 6'b10_00_00; ReqCount = 12'h101;
        exp_q.push_back(ev(0, 0, 1));
        exp_q.push_back(ev(1, 0, 1 + PER));
        exp_q.push_back(ev(0, 2, 2 + PER));
        exp_q.push_back(ev(1, 2, 2 + 2 * PER));
        run(110, 0, 3'b000);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            a = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            b = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vec++;
            if (b !== a) begin miss++; $display("FAIL priority_event: got %0d want %0d", b, a); end
        end
        vec++;
        if (buz_tr[PER + 3] !== t2k_tr[PER + 3]) begin
            miss++; $display("FAIL priority_tone2k: got %b want %b", buz_tr[PER + 3], t2k_tr[PER + 3]);
        end
    endtask

    task automatic test_count_zero;
        int a, b;
        @(negedge Clk);
        Req = 3'b100; ReqTone = 6'b01_00_00; ReqCount = 12'h000;
        exp_q.push_back(ev(0, 2, 1));
        exp_q.push_back(ev(1, 2, 1));
        run(6, 0, 3'b000);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            a = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            b = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vec++;
            if (b !== a) begin miss++; $display("FAIL count0_event: got %0d want %0d", b, a); end
        end
        for (int s = 1; s <= 6; s++) begin
            vec++;
            if (busy_tr[s] !== 1'b0 || own_tr[s] !== 2'd3) begin
                miss++; $display("FAIL count0_idle step %0d: got busy %b owner %0d want 0 3", s, busy_tr[s], own_tr[s]);
            end
        end
    endtask

    task automatic test_silent;
        int a, b;
        @(negedge Clk);
        Req = 3'b001; ReqTone = 6'b00_00_11; ReqCount = 12'h002;
        exp_q.push_back(ev(0, 0, 1));
        exp_q.push_back(ev(1, 0, 1 + 2 * PER));
        run(110, 0, 3'b000);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            a = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            b = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vec++;
            if (b !== a) begin miss++; $display("FAIL silent_event: got %0d want %0d", b, a); end
        end
        for (int s = 1; s <= 110; s++) begin
            vec++;
            if (buz_tr[s] !== 1'b0) begin miss++; $display("FAIL silent_buzzer step %0d: got %b want 0", s, buz_tr[s]); end
        end
    endtask

    task automatic test_preempt;
        int a, b;
        @(negedge Clk);
        Req = 3'b100; ReqTone = 6'b01_00_00; ReqCount = 12'h201;
        exp_q.push_back(ev(0, 2, 1));
`ifdef BEEP_PREEMPT_EN
        exp_q.push_back(ev(2, 2, 26));
        exp_q.push_back(ev(0, 0, 27));
        exp_q.push_back(ev(1, 0, 27 + PER));
`else
        exp_q.push_back(ev(1, 2, 1 + 2 * PER));
        exp_q.push_back(ev(0, 0, 2 + 2 * PER));
        exp_q.push_back(ev(1, 0, 2 + 3 * PER));
`endif
        run(160, 25, 3'b001);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            a = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            b = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vec++;
            if (b !== a) begin miss++; $display("FAIL preempt_event: got %0d want %0d", b, a); end
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] got;
        @(negedge Clk);
        Req = 3'b010; ReqTone = 6'b00_10_00; ReqCount = 12'h020;
        run(10, 0, 3'b000);
        #2;
        Rst_n = 1'b0;
        #1;
        got = {Buzzer, Busy, Owner, Ack, Done, Abort};
        vec++;
        if (got !== 11'b00_11_000_000_000) begin
            miss++; $display("FAIL reset_mid_async: got %b want 00110000000", got);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        run(120, 0, 3'b000);
        vec++;
        if (obs_q.size() !== 0) begin
            miss++; $display("FAIL reset_mid_no_events: got %0d events want 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_priority;
        test_count_zero;
        test_silent;
        test_preempt;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/beep_sequencer.md
# beep_sequencer

Arbitrates three beep requesters (alarm, error, key-click) onto a single buzzer output, using the 500 Hz / 1 kHz / 2 kHz square waves generated by the frequency divider. A granted request plays N on/off beeps at its chosen tone, with millisecond-accurate durations derived from the system clock. The block sits between the control FSMs and the buzzer pin, in the same clock domain as the divider.

## Interface
- `CLK_HZ`, 40_000_000, system clock frequency; one ms = `CLK_HZ/1000` cycles (integer, ≥2).
- `ON_MS`, 100, tone-on duration per beep in ms (1..1023).
- `OFF_MS`, 100, silent gap after each beep in ms (1..1023).

Ports:
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Rst_n`  in  1  asynchronous active-low reset.
- `Tone500`, `Tone1k`, `Tone2k`  in  1 each  divider square waves, synchronous to `Clk`.
- `Req`  in  3  request levels; bit 0 = highest priority (alarm), bit 2 = lowest (click).
- `ReqTone`  in  6  2 bits per requester (`[2i+1:2i]`): 00 = 500 Hz, 01 = 1 kHz, 10 = 2 kHz, 11 = silent.
- `ReqCount`  in  12  4 bits per requester (`[4i+3:4i]`): beep count, 0..15.
- `Ack`  out  3  one-cycle pulse: request accepted and its config latched.
- `Done`  out  3  one-cycle pulse: pattern completed.
- `Abort`  out  3  one-cycle pulse: pattern preempted (only with `BEEP_PREEMPT_EN`).
- `Busy`  out  1  high while not IDLE.
- `Owner`  out  2  index of the current owner; 3 when idle.
- `Buzzer`  out  1  registered buzzer drive.

## Operation
- States: IDLE, ON, OFF.
- IDLE: if any `Req` bit is set, the lowest index wins. That cycle: latch the owner's tone and count, pulse `Ack[i]`, reset the ms prescaler and phase counter, and go to ON. If count = 0: pulse `Ack[i]` and `Done[i]` in the same cycle and stay in IDLE.
- Requester protocol: hold `Req[i]` until `Ack[i]`, then drop it. A `Req[i]` still high the cycle after `Ack` counts as a new request.
- ON: lasts `ON_MS` ms, then go to OFF.
- OFF: lasts `OFF_MS` ms. Then decrement the remaining count. If the new count is 0, pulse `Done[owner]` and go to IDLE; otherwise go to ON.
- Every beep, including the last, is followed by its OFF gap.
- Requests that arrive while busy wait; they are arbitrated in the first IDLE cycle.
- `Buzzer` ← selected tone input when the state is ON; 0 in IDLE and OFF. Code 11 drives 0 throughout.
- Prescaler: free counter `0..CLK_HZ/1000-1` producing a ms tick; restarted on every grant.
- Phase counter: 10 bits; reloaded on every state entry; decremented on each ms tick.

## Timing
- Reset values: `Ack`, `Done`, `Abort`, `Busy`, `Buzzer` = 0; `Owner` = 3; state IDLE; all counters 0.
- Grant latency: `Req` high in IDLE at edge k produces `Ack` and `Busy` high after edge k.
- `Buzzer` lags the tone input by 1 cycle.
- Exact durations: ON = `ON_MS·CLK_HZ/1000` cycles, OFF = `OFF_MS·CLK_HZ/1000` cycles.
- Total pattern: count·(ON_MS+OFF_MS)·CLK_HZ/1000 cycles from `Ack` to `Done`.
- `Done` and the return to IDLE occur on the same edge. A pending request is granted on the next edge, so there is 1 idle cycle between patterns.
- Reset mid-pattern: outputs drop immediately (asynchronously). No `Done` or `Abort` is issued.

## Configuration
- `BEEP_PREEMPT_EN` defined: in ON or OFF, if any `Req[j]` with j < owner is high, then on that edge pulse `Abort[owner]`, go to IDLE, and force `Buzzer` to 0. The new request is granted on the next edge. The aborted requester is not resumed.
- `BEEP_PREEMPT_EN` undefined: no preemption; `Abort` is tied to 0; higher-priority requests wait for `Done`.

## Test plan
All scenarios use CLK_HZ=10_000 (10 cycles/ms), ON_MS=2, OFF_MS=3, with bench-driven tone waves.
- Reset held, toggle tones → `Buzzer`=0, `Owner`=3, `Busy`=0; release → still idle.
- Req[1], tone 01, count 3 → `Ack[1]` after 1 cycle; `Buzzer` follows Tone1k for 20 cycles, then is 0 for 30 cycles, ×3; `Done[1]` at 150 cycles after `Ack`.
- Req[2] and Req[0] raised on the same cycle → `Ack[0]` first; `Ack[2]` 1 cycle after `Done[0]`.
- Count 0 on Req[2] → `Ack[2]` and `Done[2]` in the same cycle; `Busy` stays 0.
- Tone 11, count 2 → `Buzzer`=0 throughout; `Done` at 100 cycles.
- Preemption: Req[2] active, Req[0] at cycle 25. With `BEEP_PREEMPT_EN`: `Abort[2]`, then `Ack[0]` 1 cycle later. Without it: `Ack[0]` 1 cycle after `Done[2]`.
